dec3to8_pulse: RTL and testbench

DEC3TO8_PULSE -- requirements
Module: dec3to8_pulse

---
 rtl/dec_pkg.sv | 17 +
 rtl/dec3to8_pulse_if.sv | 28 ++
 rtl/dec3to8_comb.sv | 14 +
 rtl/dec3to8_pulse.sv | 101 ++++++++++
 tb/tb_dec3to8_pulse.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/dec_pkg.sv
// Shared definitions for the pulse decoder.
// Holds the FSM state encoding and the down-counter width used by
// dec3to8_pulse.
package dec_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/dec3to8_pulse_if.sv
// Handshake/output bundle for dec3to8_pulse.
//   en        : block enable (low aborts a pulse in progress)
//   in_valid  : in_code carries a code to decode
//   in_code   : 3-bit binary code
//   in_ready  : block accepts a code this cycle
//   y         : registered one-hot decode
//   out_valid : y is non-zero
//   busy      : pulse or post-pulse gap in progress
// master drives the request side; slave is the decoder.
interface dec3to8_pulse_if;
  logic       en;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] y;
  logic       out_valid;
  logic       busy;

  modport master (
    output en, in_valid, in_code,
    input  in_ready, y, out_valid, busy
  );

  modport slave (
    input  en, in_valid, in_code,
    output in_ready, y, out_valid, busy
  );
endinterface

// File: rtl/dec3to8_comb.sv
// Purely combinational 3-to-8 one-hot decoder.
//   code   : binary code 0..7
//   onehot : onehot[k] = 1 iff code == k
module dec3to8_comb (
  input  logic [2:0] code,
  output logic [7:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/dec3to8_pulse.sv
// Decodes an accepted 3-bit code into a one-hot pulse held for PULSE_LEN
// cycles, followed by GAP_LEN forced idle cycles before the next code.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : en/in_valid/in_code in; in_ready/y/out_valid/busy out
// Parameters: PULSE_LEN (1..255), GAP_LEN (0..255).
module dec3to8_pulse
  import dec_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  dec3to8_pulse_if.slave   bus
);

  if (PULSE_LEN < 1 || PULSE_LEN > CNT_MAX) begin : g_bad_pulse_len
    $error("dec3to8_pulse: PULSE_LEN out of range 1..255");
  end
  if (GAP_LEN > CNT_MAX) begin : g_bad_gap_len
    $error("dec3to8_pulse: GAP_LEN out of range 0..255");
  end

  state_t     state, state_nx;
  cnt_t       cnt, cnt_nx;
  logic [7:0] y_q, y_nx;
  logic [7:0] dec;

  dec3to8_comb u_dec (
    .code   (bus.in_code),
    .onehot (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      y_q   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      y_q   <= y_nx;
    end
  end

  // The counter holds "remaining cycles minus one" in DRIVE and GAP, so the
  // exit decision is taken on the edge where it already reads zero.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    y_nx     = y_q;
    if (!bus.en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      y_nx     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state_nx = DRIVE;
            cnt_nx   = cnt_t'(PULSE_LEN - 1);
            y_nx     = dec;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            y_nx = '0;
            if (GAP_LEN > 0) begin
              state_nx = GAP;
              cnt_nx   = cnt_t'(GAP_LEN - 1);
            end else begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end
          end else begin
            cnt_nx = cnt - cnt_t'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt - cnt_t'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          y_nx     = '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && bus.en;
  assign bus.y         = y_q;
  assign bus.out_valid = |y_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_dec3to8_pulse.sv
// Bench for dec3to8_pulse: three instances with different pulse/gap
// lengths share the same stimulus and are compared against a timestamp
// model (pulse end / busy end expressed as edge numbers).
module tb_dec3to8_pulse;

  localparam int NDUT = 3;
  localparam int unsigned PL [NDUT] = '{4, 1, 3};
  localparam int unsigned GL [NDUT] = '{1, 0, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dec3to8_pulse_if ifa ();
  dec3to8_pulse_if ifb ();
  dec3to8_pulse_if ifc ();

  dec3to8_pulse #(.PULSE_LEN(4), .GAP_LEN(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dec3to8_pulse #(.PULSE_LEN(1), .GAP_LEN(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  dec3to8_pulse #(.PULSE_LEN(3), .GAP_LEN(2)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  logic [7:0] y_o    [NDUT];
  logic       rdy_o  [NDUT];
  logic       ov_o   [NDUT];
  logic       busy_o [NDUT];

  assign y_o[0] = ifa.y;  assign rdy_o[0] = ifa.in_ready;
  assign y_o[1] = ifb.y;  assign rdy_o[1] = ifb.in_ready;
  assign y_o[2] = ifc.y;  assign rdy_o[2] = ifc.in_ready;
  assign ov_o[0] = ifa.out_valid;  assign busy_o[0] = ifa.busy;
  assign ov_o[1] = ifb.out_valid;  assign busy_o[1] = ifb.busy;
  assign ov_o[2] = ifc.out_valid;  assign busy_o[2] = ifc.busy;

  // Model: after edge k, y shows the code while k < pulse_end, and the
  // block is busy while k < busy_end.
  int unsigned k = 0;
  int unsigned pulse_end [NDUT] = '{0, 0, 0};
  int unsigned busy_end  [NDUT] = '{0, 0, 0};
  logic [2:0]  m_code    [NDUT] = '{3'd0, 3'd0, 3'd0};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic vld, input logic [2:0] code);
    ifa.en = en; ifa.in_valid = vld; ifa.in_code = code;
    ifb.en = en; ifb.in_valid = vld; ifb.in_code = code;
    ifc.en = en; ifc.in_valid = vld; ifc.in_code = code;
  endtask

  // One clock cycle: optional async reset pulse while clk is low, then
  // drive inputs, check in_ready, take the edge and check outputs.
  task automatic step(input logic en, input logic vld, input logic [2:0] code,
                      input logic do_rst = 1'b0);
    logic       idle [NDUT];
    logic [7:0] exp_y;
    @(negedge clk);
    if (do_rst) begin
      rst = 1'b1;
      #1;
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("rst_y[%0d]", i), y_o[i], 8'h00);
        check($sformatf("rst_busy[%0d]", i), busy_o[i], 1'b0);
        check($sformatf("rst_ov[%0d]", i), ov_o[i], 1'b0);
        pulse_end[i] = k;
        busy_end[i]  = k;
      end
      rst = 1'b0;
    end
    drive(en, vld, code);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      idle[i] = (k >= busy_end[i]);
      check($sformatf("in_ready[%0d]", i), rdy_o[i], en && idle[i]);
    end
    @(posedge clk);
    k++;
    for (int i = 0; i < NDUT; i++) begin
      if (!en) begin
        pulse_end[i] = k;
        busy_end[i]  = k;
      end else if (idle[i] && vld) begin
        m_code[i]    = code;
        pulse_end[i] = k + PL[i];
        busy_end[i]  = k + PL[i] + GL[i];
      end
    end
    #1;
    for (int i = 0; i < NDUT; i++) begin
      exp_y = (k < pulse_end[i]) ? (8'h01 << m_code[i]) : 8'h00;
      check($sformatf("y[%0d]@%0d", i, k), y_o[i], exp_y);
      check($sformatf("out_valid[%0d]", i), ov_o[i], exp_y != 8'h00);
      check($sformatf("busy[%0d]", i), busy_o[i], k < busy_end[i]);
      check($sformatf("onehot[%0d]", i), $countones(y_o[i]) <= 1, 1'b1);
    end
  endtask

  logic [7:0] b_seq [4];

  initial begin
    drive(1'b0, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    check("init_y", ifa.y, 8'h00);
    check("init_busy", ifa.busy, 1'b0);
    check("init_ready", ifa.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Basic pulse on defaults: 08 held four cycles, one gap, then ready.
    step(1, 1, 3'd3);
    check("basic_first", ifa.y, 8'h08);
    repeat (3) step(1, 0, 3'd0);
    check("basic_last", ifa.y, 8'h08);
    step(1, 0, 3'd0);
    check("basic_gap", ifa.y, 8'h00);
    step(1, 0, 3'd0);
    check("basic_ready", ifa.in_ready, 1'b1);

    // Async reset in the middle of a 0x20 pulse.
    step(1, 1, 3'd5);
    step(1, 0, 3'd5);
    check("pre_rst_y", ifa.y, 8'h20);
    step(1, 0, 3'd0, 1'b1);

    // Sweep all codes.
    for (int c = 0; c < 8; c++) begin
      step(1, 1, 3'(c));
      check($sformatf("sweep_%0d", c), ifa.y, 8'h01 << c);
      repeat (5) step(1, 0, 3'(c));
    end

    // Back-pressure: code changes to 6 while the 5-pulse is running.
    step(1, 1, 3'd5);
    check("bp_first", ifa.y, 8'h20);
    repeat (5) step(1, 1, 3'd6);
    step(1, 1, 3'd6);
    check("bp_second", ifa.y, 8'h40);
    repeat (8) step(1, 0, 3'd0);

    // Abort on the second DRIVE cycle, then a full 0x80 pulse.
    step(1, 1, 3'd5);
    step(1, 0, 3'd5);
    step(0, 0, 3'd5);
    check("abort_y", ifa.y, 8'h00);
    check("abort_busy", ifa.busy, 1'b0);
    step(1, 1, 3'd7);
    check("abort_restart", ifa.y, 8'h80);
    repeat (6) step(1, 0, 3'd0);

    // PULSE_LEN=1, GAP_LEN=0 instance with continuous valid.
    step(1, 0, 3'd0, 1'b1);
    step(1, 1, 3'd1); b_seq[0] = ifb.y;
    step(1, 1, 3'd2); b_seq[1] = ifb.y;
    step(1, 1, 3'd2); b_seq[2] = ifb.y;
    step(1, 1, 3'd2); b_seq[3] = ifb.y;
    check("b2b_0", b_seq[0], 8'h02);
    check("b2b_1", b_seq[1], 8'h00);
    check("b2b_2", b_seq[2], 8'h04);
    check("b2b_3", b_seq[3], 8'h00);
    repeat (6) step(1, 0, 3'd0);

    // Random traffic with occasional disable and reset.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 11) != 0, $urandom_range(0, 2) != 0,
           3'($urandom_range(0, 7)), $urandom_range(0, 59) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
